uart_tx_fc: RTL and testbench
=============================

UART_TX_FC -- requirements
Module: uart_tx_fc

Interface
REQ-001 Parameter ClkFreqHz, default 25000000, meaning input clock frequency in Hz.
REQ-002 Parameter BaudRate, default 115200, meaning serial bit rate; ClksPerBit = floor(ClkFreqHz/BaudRate), and ClksPerBit SHALL be >= 2 (elaboration error otherwise).
REQ-003 Parameter DataWidth, default 8, meaning payload bits per frame.
REQ-004 clk_i  input  1  the one clock; all state SHALL be clocked on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous and active-high.
REQ-006 valid_i  input  1  upstream byte valid.
REQ-007 ready_o  output  1  block accepts data_i this cycle.
REQ-008 data_i  input  DataWidth  payload byte.
REQ-009 peer_rts_i  input  1  asynchronous flow control from the far-end receiver; high means the peer requests a hold.
REQ-010 tx_serial_o  output  1  UART serial line, idle high.
REQ-011 busy_o  output  1  a frame is held or being shifted.

Function
REQ-012 peer_rts_i SHALL pass through a two-flop synchronizer before use; rts_q denotes the synchronized value.
REQ-013 FSM states: IDLE, START, DATA, PARITY (only when compiled in), STOP.
REQ-014 ready_o SHALL equal (state == IDLE) AND NOT rts_q, combinationally.
REQ-015 A handshake occurs on a cycle with valid_i and ready_o both high; data_i SHALL be captured into a shift register and the FSM SHALL move to START.
REQ-016 tx_serial_o SHALL be registered: low from the edge following the handshake; each bit SHALL last exactly ClksPerBit clocks.
REQ-017 Frame order: start bit (0), DataWidth data bits LSB first, optional parity bit, one stop bit (1).
REQ-018 A baud counter SHALL count 0..ClksPerBit-1 and wrap to 0 at each bit boundary; a bit counter SHALL count 0..DataWidth-1 in DATA.
REQ-019 After the last STOP clock the FSM SHALL return to IDLE; a new start bit SHALL not begin earlier than one clock after IDLE is entered (minimum one-clock extra idle between frames).
REQ-020 rts_q rising during START/DATA/PARITY/STOP SHALL NOT interrupt the frame; it only blocks the next handshake.
REQ-021 valid_i while ready_o is low SHALL be ignored; data_i is not sampled.
REQ-022 busy_o SHALL be high in every state except IDLE.
REQ-023 tx_serial_o SHALL be high in IDLE.

Reset
REQ-024 On rst_i high, asynchronously: state IDLE, tx_serial_o 1, busy_o 0, counters 0, shift register 0.
REQ-025 Both synchronizer flops SHALL reset to 1 (held), so ready_o stays 0 until two clocks after peer_rts_i is low post-reset.
REQ-026 Reset asserted mid-frame SHALL abort the frame; the line returns high immediately and the byte is discarded.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, an even-parity bit (XOR of all data bits) SHALL be sent in state PARITY between the last data bit and the stop bit, giving an 11-bit frame for DataWidth 8.
REQ-028 Without UART_TX_PARITY_EN, PARITY state and its logic SHALL not exist; DATA SHALL go directly to STOP (10-bit frame).

Verification (ClkFreqHz=1000000, BaudRate=100000, ClksPerBit=10)
REQ-029 Reset release, peer_rts_i=0, send 0xA5 -> tx_serial_o, sampled mid-bit, = 0,1,0,1,0,0,1,0,1,1 (100 clocks, no parity); with macro = 0,1,0,1,0,0,1,0,1,0,1 (110 clocks).
REQ-030 peer_rts_i=1 held, valid_i=1 with 0x3C -> ready_o stays 0, line stays high; drop peer_rts_i -> ready_o rises exactly 2 clocks later and frame 0x3C follows.
REQ-031 Raise peer_rts_i during data bit 3 of 0xFF -> frame completes all bits plus stop; ready_o remains 0 afterward until peer_rts_i falls.
REQ-032 Back-to-back 0x00 then 0xFF with valid_i always high -> second start bit falls no sooner than ClksPerBit+1 clocks after first stop bit starts; busy_o low for exactly the IDLE clock between.
REQ-033 Assert rst_i during data bit 5 -> tx_serial_o=1, busy_o=0 same cycle; after release and 2 clocks with peer_rts_i=0, ready_o=1.
REQ-034 With macro, 0x07 (three ones) -> parity bit 1; 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_fc.sv
// UART transmitter with peer RTS flow control: start bit, LSB-first payload, one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the payload and the stop bit.
module uart_tx_fc #(
    parameter int unsigned ClkFreqHz = 25000000,
    parameter int unsigned BaudRate  = 115200,
    parameter int unsigned DataWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 peer_rts_i,
    output logic                 tx_serial_o,
    output logic                 busy_o
);

    localparam int unsigned ClksPerBit = ClkFreqHz / BaudRate;
    localparam int unsigned BaudW      = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam int unsigned BitW       = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DataWidth - 1);

    generate
        if (ClksPerBit < 2) begin : g_bad_baud
            $error("uart_tx_fc: ClkFreqHz/BaudRate must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [BaudW-1:0]       baud_q, baud_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [DataWidth-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   rts_meta_q, rts_q;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    assign ready_o     = (state_q == StIdle) && !rts_q;
    assign tx_serial_o = tx_q;
    assign busy_o      = busy_q;
    assign bit_end     = (baud_q == BaudLast);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (valid_i && ready_o) begin
                    shift_d = data_i;
                    state_d = StStart;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data_i;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // Synchronizer resets to "hold" so nothing is accepted until the peer is seen idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            rts_meta_q <= 1'b1;
            rts_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            rts_meta_q <= peer_rts_i;
            rts_q      <= rts_meta_q;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fc.sv
// Directed and randomized bench for uart_tx_fc; frames are predicted from the frame format
// and sampled mid-bit.
module tb_uart_tx_fc;

    localparam int unsigned Clks = 10;
    localparam int unsigned DW   = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBits = DW + 3;
`else
    localparam int unsigned NBits = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          peer_rts;
    logic          tx;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_fc #(
        .ClkFreqHz(1000000),
        .BaudRate (100000),
        .DataWidth(DW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid),
        .ready_o    (ready),
        .data_i     (data),
        .peer_rts_i (peer_rts),
        .tx_serial_o(tx),
        .busy_o     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of frame bit k: start 0, payload LSB first, optional even parity, stop 1.
    function automatic logic exp_bit(input logic [DW-1:0] d, input int k);
        logic [DW+2:0] frame;
        frame         = '1;
        frame[0]      = 1'b0;
        frame[DW:1]   = d;
`ifdef UART_TX_PARITY_EN
        frame[DW+1]   = ^d;
`endif
        return frame[k];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (!ready && t < 300) begin
            tick(1);
            t++;
        end
        chk({tag, " ready_timeout"}, ready, 1);
    endtask

    // Called #1 after the handshake edge; returns #1 after the edge that re-enters idle.
    task automatic check_frame(input logic [DW-1:0] d, input int rts_bit, input string tag);
        chk({tag, " start_edge_tx"}, tx, 0);
        chk({tag, " start_edge_busy"}, busy, 1);
        tick(Clks / 2);
        for (int k = 0; k < int'(NBits); k++) begin
            if (k > 0) tick(Clks);
            chk($sformatf("%s bit%0d", tag, k), tx, exp_bit(d, k));
            chk($sformatf("%s busy%0d", tag, k), busy, 1);
            if (k == rts_bit) peer_rts = 1'b1;
        end
        tick(Clks - Clks / 2);
        chk({tag, " idle_busy"}, busy, 0);
        chk({tag, " idle_tx"}, tx, 1);
    endtask

    task automatic send(input logic [DW-1:0] d, input int rts_bit, input string tag);
        valid = 1'b1;
        data  = d;
        wait_ready(tag);
        tick(1);
        valid = 1'b0;
        data  = DW'($urandom);
        check_frame(d, rts_bit, tag);
    endtask

    initial begin
        rst      = 1'b1;
        peer_rts = 1'b0;
        valid    = 1'b0;
        data     = '0;
        tick(2);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_ready", ready, 0);
        rst = 1'b0;
        tick(1);
        chk("post_reset_ready_1clk", ready, 0);
        tick(1);
        chk("post_reset_ready_2clk", ready, 1);

        send(8'hA5, -1, "a5");

        // Peer holds: valid must be ignored and the line stay idle.
        peer_rts = 1'b1;
        tick(2);
        valid = 1'b1;
        data  = 8'h3C;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk($sformatf("hold_ready%0d", i), ready, 0);
            chk($sformatf("hold_tx%0d", i), tx, 1);
        end
        peer_rts = 1'b0;
        tick(1);
        chk("release_ready_1clk", ready, 0);
        tick(1);
        chk("release_ready_2clk", ready, 1);
        tick(1);
        valid = 1'b0;
        check_frame(8'h3C, -1, "3c");

        // RTS raised during payload bit 3 (frame bit 4) must not cut the frame.
        send(8'hFF, 4, "ff_rts");
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk($sformatf("rts_after_ready%0d", i), ready, 0);
        end
        peer_rts = 1'b0;
        tick(2);
        chk("rts_drop_ready", ready, 1);

        // Back-to-back with valid held: exactly one idle clock between frames.
        valid = 1'b1;
        data  = 8'h00;
        wait_ready("b2b");
        tick(1);
        data = 8'hFF;
        check_frame(8'h00, -1, "b2b0");
        chk("b2b_gap_ready", ready, 1);
        tick(1);
        valid = 1'b0;
        check_frame(8'hFF, -1, "b2b1");

        // Reset in the middle of payload bit 5.
        valid = 1'b1;
        data  = 8'h5A;
        wait_ready("rst_mid");
        tick(1);
        valid = 1'b0;
        tick(6 * Clks + Clks / 2);
        chk("rst_mid_bit5", tx, exp_bit(8'h5A, 6));
        rst = 1'b1;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", ready, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("rst_mid_ready_1clk", ready, 0);
        tick(1);
        chk("rst_mid_ready_2clk", ready, 1);
        chk("rst_mid_line_idle", tx, 1);

        send(8'h07, -1, "par07");
        send(8'h03, -1, "par03");

        for (int i = 0; i < 8; i++) begin
            tick($urandom_range(0, 5));
            send(DW'($urandom), -1, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
